// File: rtl/led_gradient_streamer_pkg.sv
// Shared types and elaboration helpers for the LED gradient streamer.
package led_gradient_streamer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_NEED_MS} state_e;

  // Enough milestones that m+1 stays in range for every LED at every phase.
  function automatic int milestones(input int leds, input int interp_log2);
    return ((leds + 2 * (1 << interp_log2) - 2) >> interp_log2) + 1;
  endfunction

  function automatic int ch_lsb(input int c, input int cbits);
    return c * cbits;
  endfunction

endpackage

// File: rtl/led_gamma_sq.sv
// Square-law gamma: keeps the upper half of v*v.
module led_gamma_sq #(
  parameter int CBITS = 8
) (
  input  logic [CBITS-1:0] v_i,
  output logic [CBITS-1:0] g_o
);

  logic [2*CBITS-1:0] sq;
  logic               unused_lo;

  assign sq        = {{CBITS{1'b0}}, v_i} * {{CBITS{1'b0}}, v_i};
  assign g_o       = sq[2*CBITS-1:CBITS];
  assign unused_lo = ^sq[CBITS-1:0];

endmodule

// File: rtl/led_gradient_streamer.sv
// Interpolates a frame of LED colours from a milestone store and streams it
// out one channel byte at a time over a valid/ready handshake.
module led_gradient_streamer
  import led_gradient_streamer_pkg::*;
#(
  parameter int LEDS        = 40,
  parameter int INTERP_LOG2 = 3,
  parameter int CHANNELS    = 3,
  parameter int CBITS       = 8,
  parameter int GAMMA       = 1
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      dir,
  input  logic                      ms_valid,
  output logic                      ms_ready,
  input  logic [CHANNELS*CBITS-1:0] ms_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CBITS-1:0]          out_data,
  output logic                      out_last,
  output logic                      busy
);

  localparam int INTERP = 1 << INTERP_LOG2;
  localparam int MS     = milestones(LEDS, INTERP_LOG2);
  localparam int PIXW   = CHANNELS * CBITS;
  localparam int LW     = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW     = $clog2(LEDS + INTERP) + 1;
  localparam int IW     = CBITS + INTERP_LOG2 + 1;
  localparam logic [INTERP_LOG2-1:0] PH_MAX = '1;

  state_e                   state_q, state_d;
  logic                     dir_q, dir_d;
  logic [LW-1:0]            led_q, led_d;
  logic [CW-1:0]            ch_q, ch_d;
  logic                     done_q, done_d;
  logic [INTERP_LOG2-1:0]   phase_q, phase_d;
  logic [MS-1:0][PIXW-1:0]  store_q, store_d;
  logic                     ov_q, ov_d;
  logic [CBITS-1:0]         od_q, od_d;
  logic                     ol_q, ol_d;

  logic [PW-1:0]            j, p, m0, m1;
  logic [INTERP_LOG2-1:0]   f;
  logic [PIXW-1:0]          px_lo, px_hi;
  logic [CBITS-1:0]         c_lo, c_hi, v, g;
  logic [IW-1:0]            acc;
  logic                     unused_acc;
  logic                     last_ch, last_led, take;

  // Interpolation datapath for the byte addressed by led_q/ch_q.
  always_comb begin
    j  = dir_q ? (PW'(LEDS - 1) - PW'(led_q)) : PW'(led_q);
    p  = j + PW'(phase_q);
    m0 = p >> INTERP_LOG2;
    m1 = m0 + PW'(1);
    f  = p[INTERP_LOG2-1:0];
    px_lo = '0;
    px_hi = '0;
    for (int k = 0; k < MS; k++) begin
      if (m0 == PW'(k)) px_lo = store_q[k];
      if (m1 == PW'(k)) px_hi = store_q[k];
    end
    c_lo = '0;
    c_hi = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CW'(c)) begin
        c_lo = px_lo[ch_lsb(c, CBITS) +: CBITS];
        c_hi = px_hi[ch_lsb(c, CBITS) +: CBITS];
      end
    end
    acc = IW'(c_hi) * IW'(f) + IW'(c_lo) * (IW'(INTERP) - IW'(f));
    v   = acc[INTERP_LOG2 +: CBITS];
  end

  assign unused_acc = ^{acc[IW-1], acc[INTERP_LOG2-1:0]};

  generate
    if (GAMMA != 0) begin : g_gamma
      led_gamma_sq #(.CBITS(CBITS)) u_gamma (.v_i(v), .g_o(g));
    end else begin : g_bypass
      assign g = v;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    led_d    = led_q;
    ch_d     = ch_q;
    done_d   = done_q;
    phase_d  = phase_q;
    store_d  = store_q;
    ov_d     = ov_q;
    od_d     = od_q;
    ol_d     = ol_q;
    last_ch  = (ch_q == CW'(CHANNELS - 1));
    last_led = (led_q == LW'(LEDS - 1));
    take     = ov_q && out_ready;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_EMIT;
          dir_d   = dir;
          led_d   = '0;
          ch_d    = '0;
          done_d  = 1'b0;
        end
      end
      ST_EMIT: begin
        if (!ov_q || out_ready) begin
          if (!done_q) begin
            ov_d = 1'b1;
            od_d = g;
            ol_d = last_ch && last_led;
            if (last_ch) begin
              ch_d = '0;
              if (last_led) done_d = 1'b1;
              else          led_d  = led_q + LW'(1);
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            ov_d = 1'b0;
            ol_d = 1'b0;
          end
        end
        if (take && ol_q) begin
          if (phase_q == PH_MAX) begin
            state_d = ST_NEED_MS;
          end else begin
            phase_d = phase_q + INTERP_LOG2'(1);
            state_d = ST_IDLE;
          end
        end
      end
      ST_NEED_MS: begin
        if (ms_valid) begin
          for (int k = 0; k < MS - 1; k++) store_d[k] = store_q[k+1];
          store_d[MS-1] = ms_data;
          phase_d       = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      led_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
      phase_q <= '0;
      store_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      store_q <= store_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign ms_ready  = (state_q == ST_NEED_MS);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_gradient_streamer.sv
// Directed bench: LEDS=4, INTERP_LOG2=1, RGB, 8-bit; a GAMMA=1 twin shares all inputs.
module tb_led_gradient_streamer;

  typedef logic [7:0] fr_t [0:11];

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        dir = 1'b0;
  logic        ms_valid = 1'b0;
  logic [23:0] ms_data = '0;
  logic        out_ready = 1'b1;
  logic        ms_ready, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic        g_ms_ready, g_out_valid, g_out_last, g_busy;
  logic [7:0]  g_out_data;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] got [0:11];
  logic [7:0] gotg [0:11];
  int   n, last_n, last_idx;
  fr_t  e_zero, e_e, eg_e, e_f, eg_f, e_g, eg_g, e_h, eg_h;

  led_gradient_streamer #(.LEDS(4), .INTERP_LOG2(1), .CHANNELS(3), .CBITS(8), .GAMMA(0)) dut (
    .CLK(CLK), .rst(rst), .frame_start(frame_start), .dir(dir),
    .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_data(ms_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));

  led_gradient_streamer #(.LEDS(4), .INTERP_LOG2(1), .CHANNELS(3), .CBITS(8), .GAMMA(1)) dut_g (
    .CLK(CLK), .rst(rst), .frame_start(frame_start), .dir(dir),
    .ms_valid(ms_valid), .ms_ready(g_ms_ready), .ms_data(ms_data),
    .out_valid(g_out_valid), .out_ready(out_ready), .out_data(g_out_data),
    .out_last(g_out_last), .busy(g_busy));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a frame and collects bytes; optional stall, mid-frame frame_start and reset.
  task automatic run_frame(input logic d, input int stall_at, input int fs_at, input int rst_at);
    int st;
    bit stalled, fin;
    logic [7:0] hold;
    logic holdl;
    n = 0; last_n = 0; last_idx = -1; st = 0; stalled = 0; fin = 0;
    hold = '0; holdl = 1'b0;
    for (int k = 0; k < 12; k++) begin got[k] = 'x; gotg[k] = 'x; end
    frame_start = 1'b1; dir = d;
    @(negedge CLK);
    frame_start = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_valid_t1", out_valid, 0);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) chk("lat_valid_t2", out_valid, 1);
      if (st > 0) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold);
        chk("stall_last", out_last, holdl);
        st--;
        if (st > 0) continue;
        out_ready = 1'b1;
      end
      if (n > 0 && !out_valid) begin
        fin = 1;
      end else if (out_valid) begin
        if (n == stall_at && !stalled) begin
          stalled = 1; st = 5; out_ready = 1'b0;
          hold = out_data; holdl = out_last;
          continue;
        end
        if (n < 12) begin got[n] = out_data; gotg[n] = g_out_data; end
        if (out_last) begin last_n++; last_idx = n; end
        n++;
        frame_start = (n == fs_at);
        if (n == rst_at) begin
          rst = 1'b1;
          @(negedge CLK);
          rst = 1'b0;
          chk("rst_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_ms_ready", ms_ready, 0);
          fin = 1;
        end
      end
    end
    frame_start = 1'b0;
    chk("frame_done", fin, 1);
  endtask

  task automatic check_frame(input string nm, input fr_t e, input fr_t eg);
    chk({nm, "_count"}, n, 12);
    chk({nm, "_last_count"}, last_n, 1);
    chk({nm, "_last_idx"}, last_idx, 11);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("%s_byte%0d", nm, k), got[k], e[k]);
      chk($sformatf("%s_gamma%0d", nm, k), gotg[k], eg[k]);
    end
  endtask

  task automatic push_ms(input logic [23:0] d);
    chk("need_ms_ready", ms_ready, 1);
    chk("need_busy", busy, 1);
    ms_valid = 1'b1; ms_data = d;
    @(negedge CLK);
    ms_valid = 1'b0;
    chk("pushed_ms_ready", ms_ready, 0);
    chk("pushed_busy", busy, 0);
  endtask

  initial begin
    e_zero = '{default: 8'h00};
    e_e  = '{8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h7F,8'h00,8'h00};
    eg_e = '{8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h3F,8'h00,8'h00};
    e_f  = '{8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h7F,8'h00,8'h00, 8'hFF,8'h00,8'h00};
    eg_f = '{8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h3F,8'h00,8'h00, 8'hFE,8'h00,8'h00};
    e_g  = '{8'h00,8'h00,8'h00, 8'h7F,8'h00,8'h00, 8'hFF,8'h00,8'h00, 8'h7F,8'h40,8'h20};
    eg_g = '{8'h00,8'h00,8'h00, 8'h3F,8'h00,8'h00, 8'hFE,8'h00,8'h00, 8'h3F,8'h10,8'h04};
    e_h  = '{8'h00,8'h80,8'h40, 8'h7F,8'h40,8'h20, 8'hFF,8'h00,8'h00, 8'h7F,8'h00,8'h00};
    eg_h = '{8'h00,8'h40,8'h10, 8'h3F,8'h10,8'h04, 8'hFE,8'h00,8'h00, 8'h3F,8'h00,8'h00};

    repeat (3) @(negedge CLK);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_last", out_last, 0);
    chk("reset_ms_ready", ms_ready, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    // Milestone offered while idle must be ignored.
    ms_valid = 1'b1; ms_data = 24'hFFFFFF;
    repeat (3) @(negedge CLK);
    ms_valid = 1'b0;
    chk("idle_ms_busy", busy, 0);
    chk("idle_ms_ready", ms_ready, 0);

    run_frame(1'b0, -1, -1, -1); check_frame("A", e_zero, e_zero);
    chk("A_busy", busy, 0);
    chk("A_ms_ready", ms_ready, 0);
    run_frame(1'b0, -1, -1, -1); check_frame("B", e_zero, e_zero);
    push_ms(24'h0000FF);
    run_frame(1'b0, -1, -1, -1); check_frame("C", e_zero, e_zero);
    chk("C_busy", busy, 0);
    run_frame(1'b0, -1, -1, -1); check_frame("D", e_zero, e_zero);
    push_ms(24'h408000);
    run_frame(1'b0, -1, -1, -1); check_frame("E", e_e, eg_e);
    chk("E_busy", busy, 0);
    run_frame(1'b0, -1, -1, -1); check_frame("F", e_f, eg_f);
    push_ms(24'h123456);
    run_frame(1'b0, 3, 7, -1); check_frame("G", e_g, eg_g);
    chk("G_busy", busy, 0);
    run_frame(1'b1, -1, -1, -1); check_frame("H", e_h, eg_h);
    push_ms(24'hFFFFFF);

    run_frame(1'b0, -1, -1, 5);
    chk("I_count", n, 5);
    chk("I_byte0", got[0], 8'hFF);
    chk("I_byte3", got[3], 8'h7F);
    chk("I_byte4", got[4], 8'h40);
    chk("I_gamma0", gotg[0], 8'hFE);
    chk("I_gamma4", gotg[4], 8'h10);

    @(negedge CLK);
    run_frame(1'b0, -1, -1, -1); check_frame("J", e_zero, e_zero);
    chk("J_busy", busy, 0);
    chk("J_ms_ready", ms_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
